// File: rtl/motor_paso_eje_if.sv
// Command/feedback bundle between the motion controller (master) and one stepper axis (slave).
interface motor_paso_eje_if;
  logic        enable;
  logic        cmd_pos;
  logic        cmd_neg;
  logic        step;
  logic        dir;
  logic [15:0] pos_actual;
  logic        busy;
  logic        fault;
  logic        at_limit;

  modport master (
    output enable, cmd_pos, cmd_neg,
    input  step, dir, pos_actual, busy, fault, at_limit
  );

  modport slave (
    input  enable, cmd_pos, cmd_neg,
    output step, dir, pos_actual, busy, fault, at_limit
  );
endinterface

// File: rtl/motor_paso_eje.sv
// Single-axis stepper driver: level step commands become timed STEP/DIR pulses, position is tracked.
// Define MOTOR_PASO_RAMPA_EN to enable the acceleration ramp on held commands.
module motor_paso_eje #(
  parameter int unsigned STEP_DIV  = 50000,
  parameter int unsigned PULSE_W   = 100,
  parameter int unsigned DIR_SETUP = 200,
  parameter int unsigned POS_MAX   = 360,
  parameter int unsigned POS_INIT  = 0,
  parameter bit          WRAP      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  motor_paso_eje_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIR_SET, PULSE_HI, PULSE_LO} state_t;

  localparam logic [15:0] POS_TOP    = 16'(POS_MAX);
  localparam logic [15:0] POS_LAST   = 16'(POS_MAX - 1);
  localparam logic [15:0] POS_RST    = 16'(POS_INIT);
  localparam logic [31:0] HI_LAST    = 32'(PULSE_W - 1);
  localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP - 1);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        dir_reg, dir_next;
  logic [15:0] pos_reg, pos_next;
  logic        fault_reg, fault_next;
  logic        step_reg, busy_reg;
  logic        want_pos, want_neg, blocked, launch;
  logic [15:0] pos_stepped;
  logic [31:0] lo_last;

`ifdef MOTOR_PASO_RAMPA_EN
  localparam logic [31:0] PER_START = 32'(4 * STEP_DIV);
  localparam logic [31:0] PER_MIN   = 32'(STEP_DIV);
  localparam logic [31:0] PER_STEP  = 32'(STEP_DIV / 2);

  logic [31:0] period_reg, period_next;

  assign lo_last = period_reg - 32'(PULSE_W) - 32'd1;
`else
  assign lo_last = 32'(STEP_DIV - PULSE_W - 1);
`endif

  assign want_pos = bus.cmd_pos & ~bus.cmd_neg;
  assign want_neg = bus.cmd_neg & ~bus.cmd_pos;
  // On a saturating axis a command pointing past its end stop is dropped without touching dir.
  assign blocked  = !WRAP && ((want_pos && pos_reg == 16'd0) || (want_neg && pos_reg == POS_TOP));
  assign launch   = bus.enable && (want_pos || want_neg) && !blocked;

  always_comb begin
    pos_stepped = pos_reg;
    if (dir_reg) begin
      if (pos_reg != 16'd0) begin
        pos_stepped = pos_reg - 16'd1;
      end else if (WRAP) begin
        pos_stepped = POS_LAST;
      end
    end else begin
      if (WRAP) begin
        pos_stepped = (pos_reg == POS_LAST) ? 16'd0 : pos_reg + 16'd1;
      end else if (pos_reg != POS_TOP) begin
        pos_stepped = pos_reg + 16'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = 32'd0;
    dir_next   = dir_reg;
    pos_next   = pos_reg;
    fault_next = fault_reg;
    case (state_reg)
      IDLE: begin
        fault_next = bus.cmd_pos & bus.cmd_neg;
        if (launch) begin
          if (want_pos == dir_reg) begin
            state_next = PULSE_HI;
          end else begin
            dir_next   = want_pos;
            state_next = (DIR_SETUP == 0) ? PULSE_HI : DIR_SET;
          end
        end
      end
      DIR_SET: begin
        if (cnt_reg == SETUP_LAST) state_next = PULSE_HI;
        else                       cnt_next   = cnt_reg + 32'd1;
      end
      PULSE_HI: begin
        if (cnt_reg == HI_LAST) begin
          state_next = PULSE_LO;
          pos_next   = pos_stepped;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      PULSE_LO: begin
        if (cnt_reg == lo_last) state_next = IDLE;
        else                    cnt_next   = cnt_reg + 32'd1;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MOTOR_PASO_RAMPA_EN
  // Any IDLE cycle that does not continue in the same direction restarts the ramp at its slowest.
  always_comb begin
    period_next = period_reg;
    if (state_reg == IDLE && (!launch || want_pos != dir_reg)) begin
      period_next = PER_START;
    end else if (state_reg == PULSE_LO && cnt_reg == lo_last) begin
      period_next = (period_reg >= PER_MIN + PER_STEP) ? period_reg - PER_STEP : PER_MIN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) period_reg <= PER_START;
    else      period_reg <= period_next;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 32'd0;
      dir_reg   <= 1'b0;
      pos_reg   <= POS_RST;
      fault_reg <= 1'b0;
      step_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      pos_reg   <= pos_next;
      fault_reg <= fault_next;
      step_reg  <= (state_next == PULSE_HI);
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign bus.step       = step_reg;
  assign bus.dir        = dir_reg;
  assign bus.pos_actual = pos_reg;
  assign bus.busy       = busy_reg;
  assign bus.fault      = fault_reg;
  assign bus.at_limit   = !WRAP && (pos_reg == 16'd0 || pos_reg == POS_TOP);

endmodule

// File: tb/tb_motor_paso_eje.sv
// Bench for motor_paso_eje: a modular axis (u0) and a saturating axis (u1) share one command stream
// and are checked every cycle against a pulse-schedule model plus directed literal checks.
module tb_motor_paso_eje;

  localparam int SD = 10;
  localparam int PW = 3;
  localparam int DS = 4;

  logic clk = 1'b0;
  logic rst;
  logic en, cp, cn;

  always #5 clk = ~clk;

  motor_paso_eje_if bus0();
  motor_paso_eje_if bus1();

  assign bus0.enable = en;
  assign bus0.cmd_pos = cp;
  assign bus0.cmd_neg = cn;
  assign bus1.enable = en;
  assign bus1.cmd_pos = cp;
  assign bus1.cmd_neg = cn;

  motor_paso_eje #(.STEP_DIV(SD), .PULSE_W(PW), .DIR_SETUP(DS), .POS_MAX(360), .POS_INIT(0), .WRAP(1'b1))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  motor_paso_eje #(.STEP_DIV(SD), .PULSE_W(PW), .DIR_SETUP(DS), .POS_MAX(3), .POS_INIT(0), .WRAP(1'b0))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  // Model: each launched step is a schedule (rise edge, high length, period) rather than a state walk.
  int m_cyc;
  int m_pos[2], m_dir[2], m_fault[2], m_hi[2], m_idle[2], m_per[2];

  int r0[64];
  int n_rise0 = 0, n_rise1 = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;
  int exp_per[8];

  function automatic int pmax(input int i);
    return (i == 0) ? 360 : 3;
  endfunction

  function automatic bit wrapv(input int i);
    return (i == 0);
  endfunction

  function automatic int moved(input int i, input int p, input int d);
    int q;
    q = (d != 0) ? p - 1 : p + 1;
    if (wrapv(i)) return (q + pmax(i)) % pmax(i);
    if (q < 0) return 0;
    if (q > pmax(i)) return pmax(i);
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_dir[i] = 0; m_fault[i] = 0;
      m_hi[i] = -1000; m_idle[i] = 0; m_per[i] = 4 * SD;
    end
  endtask

  task automatic model_step();
    m_cyc++;
    for (int i = 0; i < 2; i++) begin
      if (m_cyc == m_hi[i] + PW) m_pos[i] = moved(i, m_pos[i], m_dir[i]);
      if (m_cyc > m_idle[i]) begin
        bit one_cmd, blk, rev;
        int per;
        one_cmd = cp ^ cn;
        m_fault[i] = int'(cp & cn);
        blk = !wrapv(i) && ((cp && m_pos[i] == 0) || (cn && m_pos[i] == pmax(i)));
        if (en && one_cmd && !blk) begin
          rev = (int'(cp) != m_dir[i]);
          per = SD;
`ifdef MOTOR_PASO_RAMPA_EN
          if (rev) m_per[i] = 4 * SD;
          per = m_per[i];
          m_per[i] = (m_per[i] - SD / 2 > SD) ? m_per[i] - SD / 2 : SD;
`endif
          m_dir[i] = int'(cp);
          m_hi[i] = m_cyc + (rev ? DS : 0);
          m_idle[i] = m_hi[i] + per;
        end
`ifdef MOTOR_PASO_RAMPA_EN
        else m_per[i] = 4 * SD;
`endif
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  task automatic cmp_inst(input int i, input logic st, input logic dr, input logic [15:0] ps,
                          input logic bz, input logic ft, input logic al);
    string p;
    p = (i == 0) ? "u0" : "u1";
    chk({p, ".step"}, st, (m_cyc >= m_hi[i] && m_cyc < m_hi[i] + PW));
    chk({p, ".dir"}, dr, m_dir[i]);
    chk({p, ".pos_actual"}, ps, m_pos[i]);
    chk({p, ".busy"}, bz, (m_cyc < m_idle[i]));
    chk({p, ".fault"}, ft, m_fault[i]);
    chk({p, ".at_limit"}, al, (!wrapv(i) && (m_pos[i] == 0 || m_pos[i] == pmax(i))));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_inst(0, bus0.step, bus0.dir, bus0.pos_actual, bus0.busy, bus0.fault, bus0.at_limit);
      cmp_inst(1, bus1.step, bus1.dir, bus1.pos_actual, bus1.busy, bus1.fault, bus1.at_limit);
      if (bus0.step && !prev0) begin
        if (n_rise0 < 64) r0[n_rise0] = m_cyc;
        n_rise0++;
        $display("step u0 cycle %0d dir %0d pos %0d", m_cyc, bus0.dir, bus0.pos_actual);
      end
      if (bus1.step && !prev1) begin
        n_rise1++;
        $display("step u1 cycle %0d dir %0d pos %0d", m_cyc, bus1.dir, bus1.pos_actual);
      end
      prev0 = bus0.step;
      prev1 = bus1.step;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus0.busy || bus1.busy) && n < 1000) begin
      tick(1);
      n++;
    end
    chk("idle_within_budget", {bus0.busy, bus1.busy}, 0);
    tick(2);
  endtask

  initial begin
    int n_save;
`ifdef MOTOR_PASO_RAMPA_EN
    exp_per = '{41, 36, 31, 26, 21, 16, 11, 11};
`else
    exp_per = '{11, 11, 11, 11, 11, 11, 11, 11};
`endif
    // Reset held with a command pending
    rst = 1'b0; en = 1'b1; cp = 1'b0; cn = 1'b1;
    tick(3);
    chk("rst_step", bus0.step, 0);
    chk("rst_dir", bus0.dir, 0);
    chk("rst_pos", bus0.pos_actual, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_fault", bus0.fault, 0);
    rst = 1'b1;
    tick(1);
    chk("first_step_rise", bus0.step, 1);
    tick(29);
    cn = 1'b0;
    tick(10);
`ifndef MOTOR_PASO_RAMPA_EN
    chk("held_pulse_count", n_rise0, 3);
    chk("rise_interval_1", r0[1] - r0[0], 11);
    chk("rise_interval_2", r0[2] - r0[1], 11);
    chk("pos_after_3", bus0.pos_actual, 3);
    chk("sat_pos_top", bus1.pos_actual, 3);
    chk("sat_at_limit_top", bus1.at_limit, 1);
`endif
    // Saturating axis at its upper stop ignores cmd_neg
    cn = 1'b1; tick(2); cn = 1'b0;
    wait_idle();
`ifndef MOTOR_PASO_RAMPA_EN
    chk("sat_hold_top", bus1.pos_actual, 3);
    chk("pos_after_4", bus0.pos_actual, 4);
`endif
    // Reset during the second PULSE_HI cycle
    cn = 1'b1; tick(1);
    chk("pre_rst_step", bus0.step, 1);
    tick(1);
    rst = 1'b0;
    #1;
    chk("midpulse_rst_step", bus0.step, 0);
    chk("midpulse_rst_pos", bus0.pos_actual, 0);
    chk("midpulse_rst_busy", bus0.busy, 0);
    cn = 1'b0; cp = 1'b1;
    tick(2);
    // Reversal with dead time, wrap 0 -> 359; saturating axis blocked at 0
    rst = 1'b1;
    tick(1);
    chk("rev_dir", bus0.dir, 1);
    chk("rev_step_low", bus0.step, 0);
    chk("rev_busy", bus0.busy, 1);
    chk("sat_dir_kept", bus1.dir, 0);
    chk("sat_at_limit_zero", bus1.at_limit, 1);
    chk("sat_blocked_busy", bus1.busy, 0);
    tick(4);
    chk("rev_step_after_setup", bus0.step, 1);
    tick(3);
    chk("rev_step_fall", bus0.step, 0);
    chk("wrap_pos", bus0.pos_actual, 359);
    cp = 1'b0;
    wait_idle();
    // Conflicting commands
    n_save = n_rise0 + n_rise1;
    cp = 1'b1; cn = 1'b1;
    tick(20);
    chk("fault_u0", bus0.fault, 1);
    chk("fault_u1", bus1.fault, 1);
    chk("fault_no_steps", n_rise0 + n_rise1, n_save);
    cn = 1'b0;
    tick(1);
    chk("fault_clear_u0", bus0.fault, 0);
    chk("fault_clear_u1", bus1.fault, 0);
    chk("post_fault_step", bus0.step, 1);
    chk("post_fault_dir", bus0.dir, 1);
    chk("sat_post_fault_step", bus1.step, 0);
    cp = 1'b0;
    wait_idle();
    chk("pos_358", bus0.pos_actual, 358);
    // cmd_neg: u0 reverses, u1 leaves the lower stop
    cn = 1'b1; tick(1); cn = 1'b0;
    wait_idle();
    chk("sat_pos_1", bus1.pos_actual, 1);
    chk("sat_off_limit", bus1.at_limit, 0);
    chk("back_pos_359", bus0.pos_actual, 359);
    chk("back_dir", bus0.dir, 0);
    // enable gating and enable dropped mid-sequence
    n_save = n_rise0;
    en = 1'b0; cn = 1'b1;
    tick(15);
    chk("disabled_no_step", n_rise0, n_save);
    chk("disabled_busy", bus0.busy, 0);
    en = 1'b1; tick(1); en = 1'b0;
    tick(30);
    wait_idle();
    chk("enable_drop_one_pulse", n_rise0, n_save + 1);
    chk("wrap_up_pos", bus0.pos_actual, 0);
    chk("sat_pos_2", bus1.pos_actual, 2);
    // Held command: rise-to-rise intervals
    n_save = n_rise0;
    en = 1'b1;
    for (int k = 0; k < 800 && n_rise0 < n_save + 9; k++) tick(1);
    cn = 1'b0;
    chk("held_rises", n_rise0 - n_save, 9);
    for (int k = 0; k < 8; k++)
      chk($sformatf("held_interval_%0d", k), r0[n_save + k + 1] - r0[n_save + k], exp_per[k]);
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
